timed_seq_prog: RTL and testbench
=================================

# timed_seq_prog

Programmable multi-step timed sequencer: the successor of the fixed-pattern timed sequence generator. It holds a writable table of up to STEPS entries, each a DATA_BITS output word with its own duration in ticks of a TICK_HZ time base derived from MAIN_HZ. It plays the table once or in a loop, with pause, restart and completion status. It drives LED, stepper or strobe patterns in the FPGA designs without resynthesis.

## Interface
- MAIN_HZ, 50_000_000, system clock frequency in Hz
- TICK_HZ, 1_000, duration time base in Hz; DIV = MAIN_HZ / TICK_HZ (integer, >= 1)
- DATA_BITS, 8, output word width
- STEPS, 16, table depth; AW = $clog2(STEPS)
- DUR_BITS, 16, per-step duration width (ticks)

Ports:
- in_clk  in  1  system clock
- in_rst  in  1  reset, asynchronous, active-high
- in_enable  in  1  run enable; low pauses playback
- in_start  in  1  start/restart pulse (level sampled per cycle)
- in_loop  in  1  1 = wrap to step 0 after last step, 0 = one-shot
- in_len  in  AW+1  number of steps to play, latched at start
- in_wr  in  1  table write strobe
- in_wr_addr  in  AW  table write address
- in_wr_data  in  DATA_BITS  word to store
- in_wr_dur  in  DUR_BITS  duration to store (ticks)
- out_data  out  DATA_BITS  current sequence word
- out_step  out  AW  index of current step
- out_busy  out  1  high in RUN
- out_done  out  1  high in DONE (one-shot finished)

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE; out_data = 0, out_step = 0, out_busy = 0, out_done = 0, prescaler = 0, remaining = 0.
- Table: STEPS x (DATA_BITS + DUR_BITS), written synchronously when in_wr, in any state. No reset of contents.
- Start: in_start with effective len L = min(in_len, STEPS) >= 1, from any state -> RUN, step 0, out_data = table[0].data, remaining = max(table[0].dur, 1), prescaler = 0, L latched. in_start with L = 0: ignored, state unchanged.
- Duration 0 is treated as 1 tick.
- Prescaler counts 0..DIV-1 only in RUN with in_enable high; tick when prescaler = DIV-1 (wraps to 0). DIV = 1: tick every enabled cycle.
- On tick: if remaining > 1, decrement. Else advance: if step < L-1, go to step+1; else if in_loop, go to step 0; else -> DONE.
- Step entry loads out_data, out_step, remaining from the table in the same edge.
- DONE: out_busy = 0, out_done = 1, out_data/out_step hold the last step's values. Left only by in_start or reset.
- in_enable low: prescaler, remaining and outputs frozen; in_start still honoured.
- in_loop is sampled at each end-of-sequence decision, not latched.

## Timing
- Start sampled at edge k: out_busy = 1, out_data = table[0] after edge k.
- Each step is visible for dur * DIV enabled cycles (dur 0 -> DIV).
- Last tick of final one-shot step at edge m: out_done = 1, out_busy = 0 after edge m.
- Write and step entry to the same address on the same edge: entry sees the old contents; new contents apply on the next entry.
- in_start in RUN: restart takes priority over any tick in that cycle.
- Async reset mid-run: outputs go to reset values immediately, independent of clock.

## Test plan
- MAIN_HZ=1_000_000, TICK_HZ=250_000 (DIV=4); table {0xA5,2},{0x3C,1},{0xFF,0}; len 3, one-shot, start -> 0xA5 for 8 cycles, 0x3C 4, 0xFF 4, then out_done=1, out_busy=0, out_data=0xFF held.
- Same table, in_loop=1 -> after 0xFF's 4 cycles, out_step=0, out_data=0xA5; period 16 cycles, out_done never set.
- in_enable low for 5 cycles during 0xA5 -> 0xA5 lasts 13 cycles total; subsequent steps unchanged.
- in_start pulse during step 1 -> next cycle out_step=0, out_data=0xA5, full 8-cycle step; in_len=0 start from IDLE -> outputs stay 0, out_busy=0.
- Write step 1 to {0x11,3} while step 1 active -> current 0x3C step unaffected; next loop pass shows 0x11 for 12 cycles.
- Assert in_rst mid-step (between clock edges) -> out_data=0, out_step=0, out_busy=0, out_done=0 immediately; start after release replays from step 0.

Source files
------------

// File: rtl/timed_seq_prog.sv
// Programmable timed sequencer: plays a writable table of (word, duration) steps
// once or in a loop, with durations counted in ticks of a divided time base.
module timed_seq_prog #(
    parameter int  MAIN_HZ   = 50_000_000,
    parameter int  TICK_HZ   = 1_000,
    parameter int  DATA_BITS = 8,
    parameter int  STEPS     = 16,
    parameter int  DUR_BITS  = 16,
    localparam int AW        = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    input  logic                 in_start,
    input  logic                 in_loop,
    input  logic [AW:0]          in_len,
    input  logic                 in_wr,
    input  logic [AW-1:0]        in_wr_addr,
    input  logic [DATA_BITS-1:0] in_wr_data,
    input  logic [DUR_BITS-1:0]  in_wr_dur,
    output logic [DATA_BITS-1:0] out_data,
    output logic [AW-1:0]        out_step,
    output logic                 out_busy,
    output logic                 out_done
);

    localparam int              DIV      = MAIN_HZ / TICK_HZ;
    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(DIV - 1);
    localparam logic [AW:0]     STEPS_W  = (AW + 1)'(STEPS);
    localparam logic [DUR_BITS-1:0] DUR_ONE = DUR_BITS'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [AW-1:0]          step_reg, step_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic [DUR_BITS-1:0]    remain_reg, remain_next;
    logic [PW-1:0]          presc_reg, presc_next;
    logic [AW:0]            len_reg, len_next;

    logic [DATA_BITS-1:0]   data_mem [STEPS];
    logic [DUR_BITS-1:0]    dur_mem  [STEPS];

    logic [AW:0]            len_eff;
    logic [AW:0]            step_inc;
    logic                   last_step;
    logic                   start_ok;
    logic                   tick;
    logic [AW-1:0]          rd_addr;
    logic [DATA_BITS-1:0]   rd_data;
    logic [DUR_BITS-1:0]    rd_dur;
    logic [DUR_BITS-1:0]    entry_dur;

    // Table write port; no reset so the arrays can map onto RAM.
    always_ff @(posedge in_clk) begin
        if (in_wr) begin
            data_mem[in_wr_addr] <= in_wr_data;
            dur_mem[in_wr_addr]  <= in_wr_dur;
        end
    end

    assign len_eff   = (in_len > STEPS_W) ? STEPS_W : in_len;
    assign start_ok  = in_start && (len_eff != '0);
    assign step_inc  = {1'b0, step_reg} + (AW + 1)'(1);
    assign last_step = (step_inc >= len_reg);
    assign tick      = (presc_reg == PRE_MAX);

    // Only one entry can happen per edge, so a single read address serves
    // start, advance and wrap; reading before the write edge yields old contents.
    assign rd_addr   = (start_ok || last_step) ? '0 : step_inc[AW-1:0];
    assign rd_data   = data_mem[rd_addr];
    assign rd_dur    = dur_mem[rd_addr];
    assign entry_dur = (rd_dur == '0) ? DUR_ONE : rd_dur;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_reg  <= IDLE;
            step_reg   <= '0;
            data_reg   <= '0;
            remain_reg <= '0;
            presc_reg  <= '0;
            len_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            step_reg   <= step_next;
            data_reg   <= data_next;
            remain_reg <= remain_next;
            presc_reg  <= presc_next;
            len_reg    <= len_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        step_next   = step_reg;
        data_next   = data_reg;
        remain_next = remain_reg;
        presc_next  = presc_reg;
        len_next    = len_reg;

        if (start_ok) begin
            // Restart wins over any tick falling in the same cycle.
            state_next  = RUN;
            step_next   = '0;
            data_next   = rd_data;
            remain_next = entry_dur;
            presc_next  = '0;
            len_next    = len_eff;
        end else if (state_reg == RUN && in_enable) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
                if (remain_reg > DUR_ONE) begin
                    remain_next = remain_reg - DUR_ONE;
                end else if (!last_step || in_loop) begin
                    step_next   = rd_addr;
                    data_next   = rd_data;
                    remain_next = entry_dur;
                end else begin
                    state_next = DONE;
                end
            end
        end
    end

    assign out_data = data_reg;
    assign out_step = step_reg;
    assign out_busy = (state_reg == RUN);
    assign out_done = (state_reg == DONE);

endmodule

// File: tb/tb_timed_seq_prog.sv
// Directed bench for timed_seq_prog with a cycle-count reference model and
// literal duration checks taken from hand-worked timing.
module tb_timed_seq_prog;

    localparam int MAIN_HZ = 1_000_000;
    localparam int TICK_HZ = 250_000;
    localparam int DIV     = MAIN_HZ / TICK_HZ;

    logic        in_clk, in_rst, in_enable, in_start, in_loop, in_wr;
    logic [4:0]  in_len;
    logic [3:0]  in_wr_addr;
    logic [7:0]  in_wr_data;
    logic [15:0] in_wr_dur;
    logic [7:0]  out_data;
    logic [3:0]  out_step;
    logic        out_busy, out_done;

    int vectors = 0;
    int errors  = 0;
    bit cmp_on  = 0;

    timed_seq_prog #(
        .MAIN_HZ(MAIN_HZ), .TICK_HZ(TICK_HZ), .DATA_BITS(8), .STEPS(16), .DUR_BITS(16)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable), .in_start(in_start),
        .in_loop(in_loop), .in_len(in_len), .in_wr(in_wr), .in_wr_addr(in_wr_addr),
        .in_wr_data(in_wr_data), .in_wr_dur(in_wr_dur), .out_data(out_data),
        .out_step(out_step), .out_busy(out_busy), .out_done(out_done)
    );

    initial in_clk = 0;
    always #5 in_clk = ~in_clk;

    // Reference model: each step lasts max(dur,1)*DIV enabled cycles.
    logic [7:0] t_data [16];
    int         t_dur  [16];
    int         m_state = 0;  // 0 idle, 1 run, 2 done
    int         m_cnt = 0, m_len = 0, m_steplen = 0, m_l = 0;
    logic [7:0] m_data = '0;
    logic [3:0] m_step = '0;

    task automatic m_enter(input int i);
        m_step    = i[3:0];
        m_data    = t_data[i];
        m_steplen = ((t_dur[i] == 0) ? 1 : t_dur[i]) * DIV;
        m_cnt     = 0;
    endtask

    always @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            m_state = 0; m_step = '0; m_data = '0; m_cnt = 0;
        end else begin
            m_l = (in_len > 5'd16) ? 16 : int'(in_len);
            if (in_start && m_l != 0) begin
                m_len = m_l;
                m_enter(0);
                m_state = 1;
            end else if (m_state == 1 && in_enable) begin
                m_cnt++;
                if (m_cnt == m_steplen) begin
                    if (int'(m_step) < m_len - 1) m_enter(int'(m_step) + 1);
                    else if (in_loop)             m_enter(0);
                    else                          m_state = 2;
                end
            end
            if (in_wr) begin
                t_data[in_wr_addr] = in_wr_data;
                t_dur[in_wr_addr]  = int'(in_wr_dur);
            end
        end
    end

    always @(negedge in_clk) begin
        if (cmp_on) begin
            vectors++;
            if ({out_data, out_step, out_busy, out_done} !==
                {m_data, m_step, m_state == 1, m_state == 2}) begin
                errors++;
                $display("FAIL model t=%0t data %h/%h step %0d/%0d busy %b/%b done %b/%b (got/required)",
                         $time, out_data, m_data, out_step, m_step, out_busy, m_state == 1,
                         out_done, m_state == 2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d, input logic [15:0] dur);
        in_wr = 1; in_wr_addr = a[3:0]; in_wr_data = d; in_wr_dur = dur;
        @(negedge in_clk);
        in_wr = 0;
    endtask

    task automatic start_pulse(input int len);
        in_len = len[4:0]; in_start = 1;
        @(negedge in_clk);
        in_start = 0;
    endtask

    task automatic count_word(input logic [7:0] w, output int n);
        n = 0;
        while (out_data === w && out_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge in_clk);
        end
    endtask

    task automatic wait_step(input logic [3:0] s);
        int k;
        k = 0;
        while (out_step !== s && k < 200) begin
            k++;
            @(negedge in_clk);
        end
        chk("wait_step", {28'd0, out_step}, {28'd0, s});
    endtask

    int n, m;

    initial begin
        in_rst = 0; in_enable = 0; in_start = 0; in_loop = 0; in_len = '0;
        in_wr = 0; in_wr_addr = '0; in_wr_data = '0; in_wr_dur = '0;
        #1 in_rst = 1;
        repeat (3) @(negedge in_clk);
        chk("reset_data", {24'd0, out_data}, 32'h0);
        chk("reset_step", {28'd0, out_step}, 32'h0);
        chk("reset_busy", {31'd0, out_busy}, 32'h0);
        chk("reset_done", {31'd0, out_done}, 32'h0);
        in_rst = 0;
        cmp_on = 1;

        for (int i = 3; i < 16; i++) wr(i, 8'(i * 17), 16'(i % 3));
        wr(0, 8'hA5, 16'd2);
        wr(1, 8'h3C, 16'd1);
        wr(2, 8'hFF, 16'd0);
        $display("table written");

        in_enable = 1; in_loop = 0;
        start_pulse(3);
        count_word(8'hA5, n); chk("oneshot_a5_len", n, 8);
        count_word(8'h3C, n); chk("oneshot_3c_len", n, 4);
        count_word(8'hFF, n); chk("oneshot_ff_len", n, 4);
        chk("oneshot_done", {31'd0, out_done}, 1);
        chk("oneshot_busy", {31'd0, out_busy}, 0);
        chk("oneshot_hold", {24'd0, out_data}, 32'hFF);
        repeat (5) @(negedge in_clk);
        chk("done_sticky", {31'd0, out_done}, 1);
        $display("one-shot run checked");

        in_loop = 1;
        start_pulse(3);
        count_word(8'hA5, n); chk("loop_a5_len", n, 8);
        count_word(8'h3C, n); chk("loop_3c_len", n, 4);
        count_word(8'hFF, n); chk("loop_ff_len", n, 4);
        chk("loop_wrap_step", {28'd0, out_step}, 0);
        chk("loop_wrap_data", {24'd0, out_data}, 32'hA5);
        chk("loop_no_done", {31'd0, out_done}, 0);
        count_word(8'hA5, n); chk("loop_a5_pass2", n, 8);
        $display("loop run checked");

        start_pulse(3);
        n = 0;
        repeat (2) begin if (out_data === 8'hA5) n++; @(negedge in_clk); end
        in_enable = 0;
        repeat (5) begin if (out_data === 8'hA5) n++; @(negedge in_clk); end
        in_enable = 1;
        count_word(8'hA5, m); chk("pause_a5_len", n + m, 13);
        count_word(8'h3C, n); chk("pause_3c_len", n, 4);
        $display("pause checked");

        wait_step(4'd1);
        start_pulse(3);
        chk("restart_step", {28'd0, out_step}, 0);
        chk("restart_data", {24'd0, out_data}, 32'hA5);
        count_word(8'hA5, n); chk("restart_a5_len", n, 8);
        $display("restart checked");

        wait_step(4'd1);
        in_wr = 1; in_wr_addr = 4'd1; in_wr_data = 8'h11; in_wr_dur = 16'd3;
        @(negedge in_clk);
        in_wr = 0;
        count_word(8'h3C, m); chk("live_write_3c_len", 1 + m, 4);
        count_word(8'hFF, n); chk("live_write_ff_len", n, 4);
        count_word(8'hA5, n); chk("live_write_a5_len", n, 8);
        count_word(8'h11, n); chk("live_write_11_len", n, 12);
        $display("live table write checked");

        @(posedge in_clk);
        #2 in_rst = 1;
        #1;
        chk("async_rst_data", {24'd0, out_data}, 32'h0);
        chk("async_rst_step", {28'd0, out_step}, 32'h0);
        chk("async_rst_busy", {31'd0, out_busy}, 32'h0);
        chk("async_rst_done", {31'd0, out_done}, 32'h0);
        @(negedge in_clk);
        in_rst = 0;
        start_pulse(0);
        chk("len0_busy", {31'd0, out_busy}, 0);
        chk("len0_data", {24'd0, out_data}, 32'h0);
        start_pulse(3);
        chk("replay_busy", {31'd0, out_busy}, 1);
        count_word(8'hA5, n); chk("replay_a5_len", n, 8);
        $display("async reset checked");

        in_loop = 0;
        start_pulse(20);
        n = 0;
        while (out_done !== 1'b1 && n < 400) begin n++; @(negedge in_clk); end
        chk("clamp_done", {31'd0, out_done}, 1);
        chk("clamp_last_step", {28'd0, out_step}, 32'd15);
        $display("length clamp checked");

        cmp_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
